// File: rtl/split_cand_scanner.sv
// Candidate generator / result collector wrapped around a combinational constraint checker.
// Optional early termination on the first hit: define SCAN_STOP_ON_HIT_EN.
module split_cand_scanner #(
    parameter int W_A      = 14,
    parameter int W_B      = 16,
    parameter int MAX_ITER = 1024,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [W_A+W_B-1:0]   seed,
    input  logic                 sat_in,
    output logic [W_A-1:0]       cand_a,
    output logic [W_B-1:0]       cand_b,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [W_A-1:0]       hit_a,
    output logic [W_B-1:0]       hit_b,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     iter_count
);

    // state | meaning
    // IDLE  | waiting for start; results and candidate hold
    // SCAN  | one candidate evaluated per cycle
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam int W_C = W_A + W_B;
    // iter_count == MAX_ITER-1 is the same test as iter_count+1 == MAX_ITER without overflow
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAX_ITER - 1);

    state_t           state, state_nxt;
    logic [W_C-1:0]   cand, cand_nxt;
    logic [W_C-1:0]   hit, hit_nxt;
    logic             found_nxt;
    logic [CNT_W-1:0] hcnt_nxt, iter_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cand       <= '0;
            hit        <= '0;
            found      <= 1'b0;
            hit_count  <= '0;
            iter_count <= '0;
        end else begin
            state      <= state_nxt;
            cand       <= cand_nxt;
            hit        <= hit_nxt;
            found      <= found_nxt;
            hit_count  <= hcnt_nxt;
            iter_count <= iter_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        hit_nxt   = hit;
        found_nxt = found;
        hcnt_nxt  = hit_count;
        iter_nxt  = iter_count;
        case (state)
            IDLE: begin
                if (start) begin
                    cand_nxt  = seed;
                    hit_nxt   = '0;
                    found_nxt = 1'b0;
                    hcnt_nxt  = '0;
                    iter_nxt  = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                // abort discards this cycle's sample and beats completion
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    iter_nxt = iter_count + CNT_W'(1);
                    if (sat_in && !found) begin
                        found_nxt = 1'b1;
                        hit_nxt   = cand;
                    end
                    if (sat_in && (hit_count != '1)) begin
                        hcnt_nxt = hit_count + CNT_W'(1);
                    end
                    if (iter_count == LAST_ITER) begin
                        state_nxt = DONE;
                    end else begin
                        cand_nxt = cand + W_C'(1);
                    end
`ifdef SCAN_STOP_ON_HIT_EN
                    if (sat_in) begin
                        state_nxt = DONE;
                        cand_nxt  = cand;
                    end
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign {cand_b, cand_a} = cand;
    assign {hit_b, hit_a}   = hit;
    assign busy             = (state == SCAN);
    assign done             = (state == DONE);

endmodule
